cpu_bus_arbiter: RTL
====================

Name: cpu_bus_arbiter

Overview:
- Single-master memory bus controller between the Beaker8 core's two internal requesters (instruction fetch port, data load/store port) and the shared system bus (ROM at 0x0000-0x3FFF, RAM/IO above).
- Grants the bus round-robin, latches address/data, drives read/write strobes for a fixed read latency, returns captured data with a one-cycle valid pulse.
- One transaction outstanding at a time; fetch pipeline and ALU datapath never drive the bus directly.

Parameters:
- ADDR_WIDTH, 16, bus address width.
- DATA_WIDTH, 8, bus data width.
- READ_LATENCY, 0, cycles from strobe to valid busDataIn (0..3); 0 = combinational ROM.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- fetchReq  in  1  instruction read request; held until fetchAck.
- fetchAddr  in  ADDR_WIDTH  instruction address (pc).
- fetchAck  out  1  one-cycle pulse: fetch request accepted.
- fetchValid  out  1  one-cycle pulse: fetchData valid.
- fetchData  out  DATA_WIDTH  returned instruction byte.
- memReq  in  1  data access request; held until memAck.
- memWrite  in  1  1 = write, 0 = read; sampled with memReq.
- memAddr  in  ADDR_WIDTH  data address.
- memWData  in  DATA_WIDTH  write data.
- memAck  out  1  one-cycle pulse: data request accepted.
- memValid  out  1  one-cycle pulse: read data valid / write done.
- memRData  out  DATA_WIDTH  read data; 0 for writes.
- busAddress  out  ADDR_WIDTH  system bus address.
- busRead  out  1  read strobe.
- busWrite  out  1  write strobe.
- busDataOut  out  DATA_WIDTH  write data to bus.
- busDataIn  in  DATA_WIDTH  read data from bus.
- busy  out  1  transaction in flight (state != IDLE).

Behaviour:
- Reset (async, reset=0): all outputs 0. State IDLE, latency counter 0, lastGrant = FETCH (next tie goes to data port). An in-flight transaction is dropped with no valid pulse. Release is synchronous to clk.
- FSM: IDLE -> ISSUE -> (WAIT if READ_LATENCY>0) -> IDLE. Every output is registered.
- IDLE:
  - On a rising edge with any req high, grant one requester and latch addr, write flag and wdata. Next cycle (T) state = ISSUE with the granted port's Ack = 1.
  - Both requesting: grant the port not equal to lastGrant. Update lastGrant on every grant.
  - No request: stay IDLE and drive all bus outputs 0.
- ISSUE (cycle T): busAddress = latched addr.
  - Read: busRead = 1.
  - Write: busWrite = 1 and busDataOut = wdata, for cycle T only.
- Reads:
  - busAddress and busRead hold from T through T+READ_LATENCY; WAIT counts down READ_LATENCY cycles.
  - busDataIn is sampled on the edge that ends cycle T+READ_LATENCY.
  - In cycle T+READ_LATENCY+1: the port's Valid = 1 and its Data = sample. State is IDLE.
- Writes: Valid pulse (memValid) in cycle T+1 with memRData = 0. State is IDLE.
- Valid cycle is an IDLE cycle, so a new grant may be taken on the edge ending it.
  - Back-to-back throughput: one read per READ_LATENCY+2 cycles, one write per 2 cycles.
- Data holding: fetchData/memRData hold their last value until the next Valid on that port. Ack/Valid are exactly one cycle.
- Request withdrawal: a requester may drop req before Ack with no side effect. Once acked, the transaction always completes unless reset.
- Protocol errors: a req held high after Ack is treated as a new request. A fetch request with memWrite high is ignored (fetch is read-only). busRead and busWrite are never high together.
- Width rules: no address arithmetic; addresses pass through unmodified, including wrap at 0xFFFF.

Test Plan:
- READ_LATENCY=0, fetchReq with fetchAddr=0x0002, ROM[2]=0xE1 -> fetchAck at T, busRead=1 / busAddress=0x0002 at T only, fetchValid=1 with fetchData=0xE1 at T+1.
- Both reqs high from reset release (fetch 0x0010, data read 0x4000) -> data granted first, fetch granted on the edge ending data's Valid cycle, then alternate while both held.
- memReq, memWrite=1, memAddr=0x8001, memWData=0x5A -> busWrite=1 for exactly one cycle with busDataOut=0x5A, memValid=1 next cycle with memRData=0.
- READ_LATENCY=2, fetch 0x0100 with busDataIn=0x3C appearing at T+2 -> busRead/busAddress held T..T+2, fetchValid at T+3 with 0x3C, busy high T..T+2.
- reset driven low during WAIT -> all outputs 0 immediately, no Valid ever issued. After release, a pending fetch+data pair grants data first.
- fetchReq pulsed 1 then dropped while a data transaction is busy -> no fetchAck, no fetch bus cycle.

Source files
------------

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: round-robin bus controller between the fetch port and the data port.
// Ports:
//   clk, reset (async, active-low)
//   fetchReq/fetchAddr -> fetchAck, fetchValid, fetchData    read-only instruction port
//   memReq/memWrite/memAddr/memWData -> memAck, memValid, memRData    load/store port
//   busAddress, busRead, busWrite, busDataOut, busDataIn    shared system bus
//   busy    a transaction is in flight
// Every output is registered. One transaction is outstanding at a time.
module cpu_bus_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetchReq,
  input  logic [ADDR_WIDTH-1:0] fetchAddr,
  output logic                  fetchAck,
  output logic                  fetchValid,
  output logic [DATA_WIDTH-1:0] fetchData,
  input  logic                  memReq,
  input  logic                  memWrite,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] memWData,
  output logic                  memAck,
  output logic                  memValid,
  output logic [DATA_WIDTH-1:0] memRData,
  output logic [ADDR_WIDTH-1:0] busAddress,
  output logic                  busRead,
  output logic                  busWrite,
  output logic [DATA_WIDTH-1:0] busDataOut,
  input  logic [DATA_WIDTH-1:0] busDataIn,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic [1:0] LAT = 2'(READ_LATENCY);
  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  last_mem_q, last_mem_d;
  logic                  port_mem_q, port_mem_d;
  logic                  wr_q, wr_d;
  logic                  fetch_ack_q, fetch_ack_d, mem_ack_q, mem_ack_d;
  logic                  fetch_valid_q, fetch_valid_d, mem_valid_q, mem_valid_d;
  logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d, mem_rdata_q, mem_rdata_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic                  bus_rd_q, bus_rd_d, bus_wr_q, bus_wr_d;
  logic [DATA_WIDTH-1:0] bus_dout_q, bus_dout_d;
  logic                  busy_q;
  logic                  grant_mem, grant_wr;
  // On a tie the port that did not win last time gets the bus.
  assign grant_mem = memReq && (!fetchReq || !last_mem_q);
  // Fetch is read-only, so memWrite only matters when the data port wins.
  assign grant_wr  = grant_mem && memWrite;
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_mem_d    = last_mem_q;
    port_mem_d    = port_mem_q;
    wr_d          = wr_q;
    fetch_ack_d   = 1'b0;
    mem_ack_d     = 1'b0;
    fetch_valid_d = 1'b0;
    mem_valid_d   = 1'b0;
    fetch_data_d  = fetch_data_q;
    mem_rdata_d   = mem_rdata_q;
    bus_addr_d    = bus_addr_q;
    bus_rd_d      = bus_rd_q;
    bus_wr_d      = 1'b0;
    bus_dout_d    = '0;
    if (state_q == IDLE) begin
      bus_addr_d = '0;
      bus_rd_d   = 1'b0;
      if (fetchReq || memReq) begin
        state_d     = ISSUE;
        cnt_d       = LAT;
        last_mem_d  = grant_mem;
        port_mem_d  = grant_mem;
        wr_d        = grant_wr;
        fetch_ack_d = !grant_mem;
        mem_ack_d   = grant_mem;
        bus_addr_d  = grant_mem ? memAddr : fetchAddr;
        bus_rd_d    = !grant_wr;
        bus_wr_d    = grant_wr;
        bus_dout_d  = grant_wr ? memWData : '0;
      end
    end else if (wr_q || cnt_q == 2'd0) begin
      // This edge ends the strobe window: capture the bus and present Valid.
      state_d       = IDLE;
      bus_addr_d    = '0;
      bus_rd_d      = 1'b0;
      fetch_valid_d = !port_mem_q;
      mem_valid_d   = port_mem_q;
      if (port_mem_q) mem_rdata_d = wr_q ? '0 : busDataIn;
      else fetch_data_d = busDataIn;
    end else begin
      state_d = WAIT;
      cnt_d   = cnt_q - 2'd1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      last_mem_q    <= 1'b0;
      port_mem_q    <= 1'b0;
      wr_q          <= 1'b0;
      fetch_ack_q   <= 1'b0;
      mem_ack_q     <= 1'b0;
      fetch_valid_q <= 1'b0;
      mem_valid_q   <= 1'b0;
      fetch_data_q  <= '0;
      mem_rdata_q   <= '0;
      bus_addr_q    <= '0;
      bus_rd_q      <= 1'b0;
      bus_wr_q      <= 1'b0;
      bus_dout_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_mem_q    <= last_mem_d;
      port_mem_q    <= port_mem_d;
      wr_q          <= wr_d;
      fetch_ack_q   <= fetch_ack_d;
      mem_ack_q     <= mem_ack_d;
      fetch_valid_q <= fetch_valid_d;
      mem_valid_q   <= mem_valid_d;
      fetch_data_q  <= fetch_data_d;
      mem_rdata_q   <= mem_rdata_d;
      bus_addr_q    <= bus_addr_d;
      bus_rd_q      <= bus_rd_d;
      bus_wr_q      <= bus_wr_d;
      bus_dout_q    <= bus_dout_d;
      busy_q        <= state_d != IDLE;
    end
  end
  assign fetchAck   = fetch_ack_q;
  assign fetchValid = fetch_valid_q;
  assign fetchData  = fetch_data_q;
  assign memAck     = mem_ack_q;
  assign memValid   = mem_valid_q;
  assign memRData   = mem_rdata_q;
  assign busAddress = bus_addr_q;
  assign busRead    = bus_rd_q;
  assign busWrite   = bus_wr_q;
  assign busDataOut = bus_dout_q;
  assign busy       = busy_q;
endmodule
